// File: rtl/sram_arbiter_mc_if.sv
// sram_arbiter_mc_if: requester bus plus SRAM pin bundle for sram_arbiter_mc.
// The slave modport is the arbiter's view, and the master modport is the
// view seen by the core/SRAM side. Channel k's field in the flattened buses
// sits at [k*W +: W].
interface sram_arbiter_mc_if #(
  parameter int NCH = 4,
  parameter int AW  = 18,
  parameter int DW  = 16
);
  localparam int BL = DW / 8;

  logic [NCH-1:0]    I_REQ;
  logic [NCH-1:0]    I_WE;
  logic [NCH*AW-1:0] I_ADDR;
  logic [NCH*DW-1:0] I_WDATA;
  logic [NCH*BL-1:0] I_BE;
  logic [NCH-1:0]    O_ACK;
  logic [DW-1:0]     O_RDATA;
  logic [AW-1:0]     O_SRAM_A;
  logic [DW-1:0]     O_SRAM_DO;
  logic [DW-1:0]     I_SRAM_DI;
  logic              O_SRAM_WE;
  logic              O_SRAM_OE;
  logic [BL-1:0]     O_SRAM_BW;
  logic              O_BUSY;

  modport slave (
    input  I_REQ, I_WE, I_ADDR, I_WDATA, I_BE, I_SRAM_DI,
    output O_ACK, O_RDATA, O_SRAM_A, O_SRAM_DO, O_SRAM_WE, O_SRAM_OE,
           O_SRAM_BW, O_BUSY
  );

  modport master (
    output I_REQ, I_WE, I_ADDR, I_WDATA, I_BE, I_SRAM_DI,
    input  O_ACK, O_RDATA, O_SRAM_A, O_SRAM_DO, O_SRAM_WE, O_SRAM_OE,
           O_SRAM_BW, O_BUSY
  );
endinterface

// File: rtl/sram_arbiter_mc.sv
// sram_arbiter_mc: round-robin arbiter for NCH requesters sharing one SRAM.
// Each access runs IDLE -> ACCESS (ACC_CYC clocks) -> RECOV (ACK) -> IDLE.
// Every output is registered.
// Optional macro SRAM_ARB_VIDEO_PRIO_EN: channel 0 (video fetch) gets strict
// priority. Channels 1..NCH-1 round-robin among themselves, and a channel 0
// grant leaves last_grant untouched.
module sram_arbiter_mc #(
  parameter int NCH     = 4,
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int ACC_CYC = 2
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET,
  sram_arbiter_mc_if.slave     bus
);
  localparam int         BL       = DW / 8;
  localparam int         CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RECOV} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] grant;
  logic          grant_vld;
  logic [CW-1:0] cur_ch;
  logic          cur_we;
  logic [3:0]    cnt;

  logic [NCH-1:0] ack_q;
  logic [DW-1:0]  rdata_q;
  logic [AW-1:0]  a_q;
  logic [DW-1:0]  do_q;
  logic [BL-1:0]  bw_q;
  logic           we_q;
  logic           oe_q;
  logic           busy_q;

  // Pick the next channel, searching from the one after last_grant.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
`ifdef SRAM_ARB_VIDEO_PRIO_EN
    if (bus.I_REQ[0]) begin
      grant_vld = 1'b1;
    end else begin
      // last_grant only ever holds 1..NCH-1 here, so wrap back to channel 1.
      for (int i = 1; i < NCH; i++) begin
        idx = int'(last_grant) + i;
        if (idx >= NCH) idx = idx - (NCH - 1);
        if (!grant_vld && bus.I_REQ[CW'(idx)]) begin
          grant_vld = 1'b1;
          grant     = CW'(idx);
        end
      end
    end
`else
    for (int i = 1; i <= NCH; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_vld && bus.I_REQ[CW'(idx)]) begin
        grant_vld = 1'b1;
        grant     = CW'(idx);
      end
    end
`endif
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (grant_vld) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == 4'd0) state_nxt = ST_RECOV;
      ST_RECOV:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    if (I_RESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Latch the granted request, run the strobe counter, and register all outputs.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      // NOTE: every output flop is reset, because all pins must read 0 while reset is held.
      last_grant <= CW'(NCH - 1);
      cur_ch     <= '0;
      cur_we     <= 1'b0;
      cnt        <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      a_q        <= '0;
      do_q       <= '0;
      bw_q       <= '0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            cur_ch <= grant;
            cur_we <= bus.I_WE[grant];
            a_q    <= bus.I_ADDR[grant*AW +: AW];
            do_q   <= bus.I_WDATA[grant*DW +: DW];
            bw_q   <= bus.I_WE[grant] ? bus.I_BE[grant*BL +: BL] : '1;
            we_q   <= bus.I_WE[grant];
            oe_q   <= ~bus.I_WE[grant];
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
`ifdef SRAM_ARB_VIDEO_PRIO_EN
            if (grant != '0) last_grant <= grant;
`else
            last_grant <= grant;
`endif
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            we_q          <= 1'b0;
            oe_q          <= 1'b0;
            ack_q[cur_ch] <= 1'b1;
            if (!cur_we) rdata_q <= bus.I_SRAM_DI;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RECOV: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.O_ACK     = ack_q;
  assign bus.O_RDATA   = rdata_q;
  assign bus.O_SRAM_A  = a_q;
  assign bus.O_SRAM_DO = do_q;
  assign bus.O_SRAM_BW = bw_q;
  assign bus.O_SRAM_WE = we_q;
  assign bus.O_SRAM_OE = oe_q;
  assign bus.O_BUSY    = busy_q;
endmodule

// File: doc/sram_arbiter_mc.md
# sram_arbiter_mc

Multi-channel arbiter for the single external SRAM shared by the X1 core. It generalises the fixed CPU/GRAM SRAM front end to NCH requesters: CPU main RAM/IPL, GRAM video fetch, and future DMA/FDD buffers. It uses a parametrised address, data and byte-lane width and a programmable access length. The block sits between the core buses and the SRAM pins. It serialises requests, drives SRAM strobes, returns read data and pulses a per-channel acknowledge.

## Interface
Parameters:
- NCH, 4: number of requesting channels (2..8).
- AW, 18: SRAM word address width.
- DW, 16: data width; must be a multiple of 8; byte lanes BL = DW/8.
- ACC_CYC, 2: strobe length in clocks (1..15).

Ports (channel k's field in flattened buses is at [k*W +: W]):
- I_CLK  in  1  system clock; all logic on rising edge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_REQ  in  NCH  per-channel request level.
- I_WE  in  NCH  per-channel write (1) / read (0).
- I_ADDR  in  NCH*AW  per-channel word address.
- I_WDATA  in  NCH*DW  per-channel write data.
- I_BE  in  NCH*BL  per-channel byte enables (writes only; reads drive all lanes).
- O_ACK  out  NCH  one-cycle completion pulse, at most one bit set.
- O_RDATA  out  DW  read data of last completed read, valid when O_ACK pulses; held until next read completes.
- O_SRAM_A  out  AW  SRAM address.
- O_SRAM_DO  out  DW  SRAM write data.
- I_SRAM_DI  in  DW  SRAM read data.
- O_SRAM_WE  out  1  write strobe, active-high.
- O_SRAM_OE  out  1  output enable, active-high.
- O_SRAM_BW  out  BL  byte-lane enables, active-high.
- O_BUSY  out  1  high in any state except IDLE.

## Operation
- FSM: IDLE -> ACCESS -> RECOV -> IDLE.
- IDLE: if any I_REQ bit is set at the clock edge, the arbiter grants one channel. It latches that channel's WE, ADDR, WDATA and BE (all lanes for reads), loads the counter with ACC_CYC-1 and enters ACCESS. With no request it stays in IDLE.
- ACCESS:
  - O_SRAM_A, O_SRAM_DO and O_SRAM_BW are driven from the latched values.
  - For a write, O_SRAM_WE=1; for a read, O_SRAM_OE=1.
  - The counter decrements each cycle. At count 0, a read captures I_SRAM_DI into O_RDATA and the FSM goes to RECOV.
- RECOV: WE and OE are 0, and A, DO and BW are held for hold time. O_ACK[granted]=1 for this cycle only. The FSM then returns to IDLE.
- Arbitration is round-robin. The search starts at (last_grant+1) mod NCH. last_grant resets to NCH-1, so channel 0 wins first after reset.
- Requester rule: hold REQ, WE, ADDR, WDATA and BE stable from assertion until the clock edge at which O_ACK is seen. After that edge, keep REQ high only to issue a new access. Because arbitration samples REQ at the end of the IDLE cycle, a held or dropped REQ never causes a spurious grant.
- Requests arriving while the FSM is busy wait; nothing is dropped and no request can be cancelled once granted.
- Reset (asynchronous, any state, including mid-ACCESS):
  - FSM goes to IDLE and any in-flight access is abandoned with no ACK.
  - All outputs go to 0: O_SRAM_A, O_SRAM_DO, O_SRAM_BW, O_SRAM_WE, O_SRAM_OE, O_ACK, O_RDATA and O_BUSY.
  - last_grant goes to NCH-1.

## Timing
- Request sampled at edge E0 (IDLE).
- ACCESS occupies cycles E0+1..E0+ACC_CYC.
- RECOV with ACK is cycle E0+ACC_CYC+1.
- Earliest next grant is sampled at E0+ACC_CYC+2.
- Peak throughput is one access per ACC_CYC+2 clocks.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SRAM_ARB_VIDEO_PRIO_EN defined:
  - Channel 0 (video fetch) has strict priority and wins whenever I_REQ[0] is set in IDLE.
  - Channels 1..NCH-1 round-robin among themselves.
  - Channel 0 does not update last_grant.
- Undefined: plain round-robin over all NCH channels.

## Test plan
- Single read: NCH=4, ACC_CYC=2, ch1 reads 0x00123 and the model returns 0xBEEF. Required: OE=1 for 2 cycles with A=0x00123, then O_ACK=4'b0010 for one cycle 3 clocks after the sampling edge, with O_RDATA=0xBEEF.
- Byte write: ch2 writes 0x5A00 with BE=2'b10 to 0x3FFFF. Required: WE=1 for 2 cycles, BW=2'b10, DO=0x5A00, then ACK[2] pulses.
- Fairness, macro off: all four REQ held high. Required: ACK order 0,1,2,3,0,1, with pulses exactly 4 clocks apart.
- Priority, macro on: ch1 and ch2 held, with ch0 pulsed for one access every 12 clocks. Required: ch0 is granted at the first IDLE after each of its requests, and ch1/ch2 alternate otherwise.
- Reset mid-ACCESS: I_RESET asserted in the first ACCESS cycle of a ch3 write. Required: WE=0 and all outputs 0 asynchronously, no ACK, and after release with all REQ high, ch0 is granted first.
- ACC_CYC=1: back-to-back reads on ch0. Required: 1-cycle OE and ACK every 3 clocks.
